// File: rtl/quad_pkg.sv
// Shared constants for the serial-to-quad deserializer.
// Lane indices map lane names onto the packed lane vector.
package quad_pkg;

  localparam int LANES = 4;
  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

  localparam int LANE_A = 3;
  localparam int LANE_B = 2;
  localparam int LANE_C = 1;
  localparam int LANE_D = 0;

  function automatic logic [LANES-1:0] rev_lanes(
    input logic [LANES-1:0] v
  );
    logic [LANES-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      r[i] = v[LANES-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_reduce.sv
// Four-lane reduction: all-set and any-set flags.
// Purely combinational; feeds the output register.
module quad_reduce
  import quad_pkg::*;
(
  input  logic [LANES-1:0] lanes,
  output logic             all_set,
  output logic             any_set
);

  assign all_set = &lanes;
  assign any_set = |lanes;

endmodule

// File: rtl/quad_deser.sv
// Serial-to-quad deserializer with a registered valid/ready
// output stage and sync-driven frame restart.
module quad_deser
  import quad_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  input  logic sin_valid,
  output logic sin_ready,
  input  logic sync,
  output logic out_a,
  output logic out_b,
  output logic out_c,
  output logic out_d,
  output logic all_set,
  output logic any_set,
  output logic out_valid,
  input  logic out_ready,
  output logic frame_err
);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       part;
  logic [LANES-1:0] lane_q;
  logic [LANES-1:0] frame;
  logic [LANES-1:0] lane_nxt;
  logic             all_nxt;
  logic             any_nxt;
  logic             all_q;
  logic             any_q;
  logic             acc;
  logic             last;
  logic             load;

  // sync restarts the frame, so the 4th-bit stall never applies
  assign last      = (cnt == CNT_MAX);
  assign sin_ready = sync | ~last | ~out_valid | out_ready;
  assign acc       = sin_valid & sin_ready;
  assign load      = acc & ~sync & last;

  assign frame    = {part[0], part[1], part[2], sin};
  assign lane_nxt = MSB_FIRST ? frame : rev_lanes(frame);

  quad_reduce u_reduce (
    .lanes   (lane_nxt),
    .all_set (all_nxt),
    .any_set (any_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      part      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= sync & (cnt != '0);
      if (sync) begin
        cnt <= acc ? CNT_W'(1) : '0;
        if (acc) part[0] <= sin;
      end else if (acc) begin
        cnt <= last ? '0 : cnt + 1'b1;
        unique case (1'b1)
          cnt == 2'd0: part[0] <= sin;
          cnt == 2'd1: part[1] <= sin;
          cnt == 2'd2: part[2] <= sin;
          last:        ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q    <= '0;
      all_q     <= 1'b0;
      any_q     <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      lane_q    <= lane_nxt;
      all_q     <= all_nxt;
      any_q     <= any_nxt;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_a   = lane_q[LANE_A];
  assign out_b   = lane_q[LANE_B];
  assign out_c   = lane_q[LANE_C];
  assign out_d   = lane_q[LANE_D];
  assign all_set = all_q;
  assign any_set = any_q;

endmodule

// File: tb/tb_quad_deser.sv
// Bench for quad_deser: both bit orders driven in parallel,
// frame-level model plus directed literal expectations.
module tb_quad_deser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin = 1'b0;
  logic sin_valid = 1'b0;
  logic sync = 1'b0;
  logic out_ready = 1'b1;

  logic rdy1, a1, b1, c1, d1, all1, any1, v1, err1;
  logic rdy0, a0, b0, c0, d0, all0, any0, v0, err0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quad_deser #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .sin_valid(sin_valid), .sin_ready(rdy1), .sync(sync),
    .out_a(a1), .out_b(b1), .out_c(c1), .out_d(d1),
    .all_set(all1), .any_set(any1), .out_valid(v1),
    .out_ready(out_ready), .frame_err(err1)
  );

  quad_deser #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .sin_valid(sin_valid), .sin_ready(rdy0), .sync(sync),
    .out_a(a0), .out_b(b0), .out_c(c0), .out_d(d0),
    .all_set(all0), .any_set(any0), .out_valid(v0),
    .out_ready(out_ready), .frame_err(err0)
  );

  // Model: a queue of accepted bits plus one held output word
  bit         part[$];
  logic [3:0] m1 = '0;
  logic [3:0] m0 = '0;
  logic       mall = 1'b0;
  logic       many = 1'b0;
  logic       mv = 1'b0;
  logic       merr = 1'b0;

  function automatic logic exp_ready();
    return sync || part.size() < 3 || !mv || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic       a;
    logic       take;
    logic [3:0] fr;
    if (!rst_n) begin
      part.delete();
      m1 = '0; m0 = '0; mall = 0; many = 0; mv = 0; merr = 0;
    end else begin
      a = sin_valid && exp_ready();
      take = mv && out_ready;
      merr = sync && part.size() != 0;
      if (sync) begin
        part.delete();
        if (a) part.push_back(sin);
        if (take) mv = 0;
      end else if (a && part.size() == 3) begin
        fr = {part[0], part[1], part[2], sin};
        m1 = fr;
        m0 = {fr[0], fr[1], fr[2], fr[3]};
        mall = fr == 4'hf;
        many = fr != 4'h0;
        mv = 1;
        part.delete();
      end else begin
        if (a) part.push_back(sin);
        if (take) mv = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_msb", {a1, b1, c1, d1, all1, any1, v1, err1, rdy1},
        {m1, mall, many, mv, merr, exp_ready()});
    chk("model_lsb", {a0, b0, c0, d0, all0, any0, v0, err0, rdy0},
        {m0, mall, many, mv, merr, exp_ready()});
  end

  task automatic send(input logic b);
    logic r;
    int   n;
    n = 0;
    sin = b;
    sin_valid = 1'b1;
    do begin
      @(negedge clk);
      r = rdy1;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 40);
    chk("send_accept", {31'd0, r}, 32'd1);
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    sync = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send4(input logic [3:0] f);
    for (int i = 3; i >= 0; i--) send(f[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {a1, b1, c1, d1, all1, any1, v1, err1, rdy1},
        32'h001);
    rst_n = 1'b1;
    idle(1);

    send4(4'b1011);
    sin_valid = 1'b0;
    chk("f1011_msb", {a1, b1, c1, d1, all1, any1, v1}, 7'b1011_011);
    chk("f1011_lsb", {a0, b0, c0, d0, all0, any0, v0}, 7'b1101_011);

    send4(4'b1111);
    chk("f1111", {a1, b1, c1, d1, all1, any1, v1}, 7'b1111_111);
    send4(4'b0000);
    chk("f0000", {a1, b1, c1, d1, all1, any1, v1}, 7'b0000_001);
    idle(2);
    chk("drained", {31'd0, v1}, 32'd0);

    out_ready = 1'b0;
    send4(4'b1100);
    chk("held_a", {a1, b1, c1, d1, v1}, 5'b1100_1);
    send(1'b0);
    send(1'b1);
    send(1'b0);
    sin = 1'b1;
    sin_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_rdy", {31'd0, rdy1}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("still_a", {a1, b1, c1, d1, v1}, 5'b1100_1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_rdy", {31'd0, rdy1}, 32'd1);
    @(posedge clk);
    #1;
    chk("frame_b", {a1, b1, c1, d1, v1}, 5'b0101_1);
    idle(1);

    send(1'b1);
    send(1'b1);
    sync = 1'b1;
    send(1'b0);
    sync = 1'b0;
    chk("sync_err", {31'd0, err1}, 32'd1);
    send(1'b1);
    chk("err_once", {31'd0, err1}, 32'd0);
    send(1'b1);
    send(1'b0);
    chk("sync_frame", {a1, b1, c1, d1, v1}, 5'b0110_1);
    idle(2);

    sync = 1'b1;
    idle(1);
    chk("sync_cnt0", {31'd0, err1}, 32'd0);

    out_ready = 1'b0;
    send4(4'b1000);
    send(1'b1);
    send(1'b1);
    send(1'b1);
    sync = 1'b1;
    send(1'b1);
    sync = 1'b0;
    chk("sync3_err", {31'd0, err1}, 32'd1);
    chk("sync3_hold", {a1, b1, c1, d1, v1}, 5'b1000_1);
    out_ready = 1'b1;
    idle(2);

    send4(4'b1111);
    out_ready = 1'b0;
    send(1'b1);
    send(1'b0);
    send(1'b1);
    sin_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {a1, b1, c1, d1, all1, any1, v1, err1, rdy1},
        32'h001);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send4(4'b0011);
    chk("post_rst", {a1, b1, c1, d1, all1, any1, v1}, 7'b0011_011);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/quad_deser.md
# quad_deser

Serial-to-quad deserializer: collects four single-bit samples from a valid/ready serial stream and presents them as four parallel lane bits (`out_a`..`out_d`) with their all-set/any-set summary. It feeds the four-input reduction blocks in this design, which need all four lane bits at once. It has one registered output stage with a valid/ready handshake, plus frame resynchronisation.

## Interface
Parameters:
- `MSB_FIRST`, default 1: 1 = first serial bit lands on `out_a`, last on `out_d`; 0 = first bit on `out_d`, last on `out_a`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` is valid this cycle.
- `sin_ready`  out  1  block accepts `sin` this cycle.
- `sync`  in  1  frame restart; discards any partial frame.
- `out_a`, `out_b`, `out_c`, `out_d`  out  1 each  registered lane bits.
- `all_set`  out  1  registered AND of the four lane bits.
- `any_set`  out  1  registered OR of the four lane bits.
- `out_valid`  out  1  lane bits and flags are valid.
- `out_ready`  in  1  downstream accepts the output.
- `frame_err`  out  1  one-cycle pulse: partial frame discarded by `sync`.

## Operation
- Accept condition: `acc = sin_valid & sin_ready`.
- Internal state:
  - 2-bit bit counter `cnt`, range 0..3.
  - 3-bit partial shift store.
  - Output register: 4 lane bits, `all_set`, `any_set`, `out_valid`.
- Readiness:
  - `sin_ready` = 1 when `cnt` < 3.
  - When `cnt` == 3, `sin_ready` = `!out_valid | out_ready`. This lets the fourth bit complete in the same cycle the held output is consumed.
- On `acc` with `cnt` < 3: store `sin` at position `cnt`, then `cnt` += 1.
- On `acc` with `cnt` == 3: load the three stored bits plus `sin` into the lane registers in `MSB_FIRST` order. Compute `all_set`/`any_set` from the same four bits. Set `out_valid` = 1 and `cnt` = 0.
- `out_valid` clears on `out_valid & out_ready` unless a new frame loads in the same cycle; a load wins and `out_valid` stays 1.
- `sync` takes priority over the counter:
  - With `acc`, the accepted bit becomes bit 0 of a new frame and `cnt` = 1.
  - Without `acc`, `cnt` = 0.
  - In both cases the output register is untouched.
- `sync` while `cnt` == 3 forces `sin_ready` = 1 regardless of output state, because the frame restarts.
- `frame_err` pulses for one cycle, the cycle after `sync` is asserted while `cnt` ≠ 0. `sync` with `cnt` == 0 produces no pulse.
- Lane and flag outputs hold their last loaded values while `out_valid` = 0.

## Timing
- Reset values:
  - `out_a`..`out_d` = 0, `all_set` = 0, `any_set` = 0.
  - `out_valid` = 0, `frame_err` = 0, `cnt` = 0.
  - `sin_ready` = 1 (combinational from `cnt`/`out_valid`).
- Latency: fourth bit accepted in cycle N → `out_valid` = 1 and data visible in cycle N+1.
- Throughput: one frame per 4 accepted bits, no bubbles while `out_ready` = 1.
- Back-pressure:
  - Output held with `out_ready` = 0 stalls only the fourth bit.
  - Bits 1–3 of the next frame are accepted meanwhile.
- Reset mid-frame: the partial frame and any pending output are lost immediately, with no `frame_err`.
- `sin_ready` must not depend on `sin_valid`; the only combinational inputs to it are `out_ready` and `sync`.

## Structure
- Package `quad_pkg`:
  - `LANES` = 4.
  - `CNT_W` = 2.
  - Lane-index constants `LANE_A`..`LANE_D`.
- One sub-module: `quad_reduce`, combinational, takes the 4-bit lane vector and returns the all/any flags. It is instantiated once, before the output register.
- Counter, partial store and output register live in `quad_deser`; no further hierarchy.

## Test plan
- Serial 1,0,1,1 with `out_ready` = 1 and `MSB_FIRST` = 1 → one cycle after the 4th bit: a=1, b=0, c=1, d=1, `all_set` = 0, `any_set` = 1, `out_valid` = 1.
- Serial 1,1,1,1 then 0,0,0,0 back-to-back → two consecutive valid frames: first `all_set` = 1 / `any_set` = 1, then `all_set` = 0 / `any_set` = 0.
- Same serial 1,0,1,1 with `MSB_FIRST` = 0 → a=1, b=1, c=0, d=1.
- Hold `out_ready` = 0 after a frame and stream 8 more bits → bits 5–7 accepted, `sin_ready` = 0 at bit 8 until `out_ready` = 1. That frame loads in the same cycle the first is consumed, and `out_valid` stays 1.
- Send 2 bits, then `sync` with `sin_valid` = 1 and bit 0, then 3 more bits → `frame_err` pulses once, and the output frame starts with the sync bit.
- Assert `rst_n` = 0 after 3 bits with `out_valid` = 1 → all outputs 0 and `cnt` = 0 immediately. After release, the next 4 bits form a complete frame.
